// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the Ethernet TX frame arbiter.
// Contents: FSM state encoding, EtherType constants, grant index width.
// Optional states ST_ABORT/ST_DRAIN exist only when ETH_TX_ARB_TIMEOUT_EN is defined.
package eth_pkg;
  localparam int GRANT_W = 3;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_IFG
`ifdef ETH_TX_ARB_TIMEOUT_EN
    ,
    ST_ABORT,
    ST_DRAIN
`endif
  } state_t;
endpackage

// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: bundle of source AXI-Stream requesters and the MAC-side stream.
// master: environment (drives source beats, EtherTypes and MAC ready).
// slave: arbiter (drives source readies, MAC stream, m_eth_type, grant_id, busy).
interface eth_tx_arbiter_if #(parameter int NUM_SRC = 2);
  import eth_pkg::*;
  logic [8*NUM_SRC-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0] s_axis_tvalid;
  logic [NUM_SRC-1:0] s_axis_tlast;
  logic [NUM_SRC-1:0] s_axis_tready;
  logic [16*NUM_SRC-1:0] s_eth_type;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic m_axis_tuser;
  logic m_axis_tready;
  logic [15:0] m_eth_type;
  logic [GRANT_W-1:0] grant_id;
  logic busy;
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_eth_type, m_axis_tready,
    input s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input m_eth_type, grant_id, busy
  );
  modport slave (
    input s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_eth_type, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_eth_type, grant_id, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker.
// Ports: req (one bit per source), last_grant (previous winner) -> grant (winner index), valid (any request).
module rr_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int GW = 3
) (
  input logic [NUM_SRC-1:0] req,
  input logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic valid
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  logic [IW-1:0] idx;
  // Scanning from the farthest candidate back to last_grant+1 lets the nearest requester win last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = IW'((int'(last_grant) + i) % NUM_SRC);
      if (req[idx]) begin
        grant = GW'(idx);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-level round-robin arbiter sharing the MAC TX byte stream among NUM_SRC sources.
// Ports: sys_clk, sys_rst (async, active high), bus (eth_tx_arbiter_if.slave: source streams,
// MAC stream, latched EtherType, grant_id, busy).
// Optional macro ETH_TX_ARB_TIMEOUT_EN adds a mid-frame stall timeout with ABORT/DRAIN states.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic sys_clk,
  input logic sys_rst,
  eth_tx_arbiter_if.slave bus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam state_t POST = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
  if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("eth_tx_arbiter: unsupported parameter set");
  end
  state_t state, state_nxt;
  logic [GRANT_W-1:0] grant_id, last_grant, pick;
  logic [IW-1:0] gi;
  logic pick_vld, g_valid, g_last, frame_done;
  logic [15:0] eth_type;
  logic [31:0] ifg_cnt;
  rr_arbiter #(.NUM_SRC(NUM_SRC), .GW(GRANT_W)) u_rr (
    .req(bus.s_axis_tvalid),
    .last_grant(last_grant),
    .grant(pick),
    .valid(pick_vld)
  );
  assign gi = grant_id[IW-1:0];
  assign g_valid = bus.s_axis_tvalid[gi];
  assign g_last = bus.s_axis_tlast[gi];
  assign bus.grant_id = grant_id;
  assign bus.m_eth_type = eth_type;
  assign bus.busy = state != ST_IDLE;
`ifdef ETH_TX_ARB_TIMEOUT_EN
  logic [31:0] stall_cnt;
  logic stall_hit;
  assign stall_hit = !g_valid && stall_cnt == 32'(TIMEOUT_CYCLES - 1);
`endif
  always_comb begin
    state_nxt = state;
    frame_done = 1'b0;
    bus.m_axis_tdata = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast = 1'b0;
    bus.m_axis_tuser = 1'b0;
    bus.s_axis_tready = '0;
    case (state)
      ST_IDLE: state_nxt = pick_vld ? ST_XFER : ST_IDLE;
      ST_XFER: begin
        bus.m_axis_tdata = bus.s_axis_tdata[8*gi +: 8];
        bus.m_axis_tvalid = g_valid;
        bus.m_axis_tlast = g_last;
        bus.s_axis_tready[gi] = bus.m_axis_tready;
        frame_done = g_valid && g_last && bus.m_axis_tready;
        state_nxt = frame_done ? POST : ST_XFER;
`ifdef ETH_TX_ARB_TIMEOUT_EN
        if (stall_hit) state_nxt = ST_ABORT;
`endif
      end
      ST_IFG: state_nxt = ifg_cnt == 32'd0 ? ST_IDLE : ST_IFG;
`ifdef ETH_TX_ARB_TIMEOUT_EN
      ST_ABORT: begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tlast = 1'b1;
        bus.m_axis_tuser = 1'b1;
        state_nxt = bus.m_axis_tready ? ST_DRAIN : ST_ABORT;
      end
      ST_DRAIN: begin
        bus.s_axis_tready[gi] = 1'b1;
        frame_done = g_valid && g_last;
        state_nxt = frame_done ? POST : ST_DRAIN;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      grant_id <= '0;
      last_grant <= GRANT_W'(NUM_SRC - 1);
      eth_type <= '0;
      ifg_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_vld) begin
        grant_id <= pick;
        eth_type <= bus.s_eth_type[16*pick[IW-1:0] +: 16];
      end
      if (frame_done) last_grant <= grant_id;
      if (frame_done) ifg_cnt <= 32'(IFG_CYCLES - 1);
      else if (state == ST_IFG) ifg_cnt <= ifg_cnt - 32'd1;
    end
  end
`ifdef ETH_TX_ARB_TIMEOUT_EN
  // Counts consecutive XFER cycles with the granted source idle; any other state clears it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) stall_cnt <= '0;
    else stall_cnt <= (state == ST_XFER && !g_valid) ? stall_cnt + 32'd1 : '0;
  end
`endif
endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Frame-level round-robin arbiter that shares the single MAC transmit byte stream between `NUM_SRC` AXI-Stream requesters, such as ARP, ICMP and UDP generators. It sits in the `sys_clk` domain directly upstream of the MAC TX byte input. It latches the winning source's EtherType for the MAC header and enforces a minimum idle gap between frames. Arbitration is never done mid-frame: a grant holds until the granted source's `tlast` beat completes.

## Interface
- `NUM_SRC`, 2: number of requesters, 2..8.
- `IFG_CYCLES`, 12: idle `sys_clk` cycles enforced after each frame's last beat.
- `TIMEOUT_CYCLES`, 1024: stall limit mid-frame; used only with the timeout feature.
- `sys_clk` in 1: the block's only clock.
- `sys_rst` in 1: asynchronous, active-high reset.
- `s_axis_tdata` in 8*NUM_SRC: source i occupies bits [8i+7:8i].
- `s_axis_tvalid` in NUM_SRC: per-source valid.
- `s_axis_tlast` in NUM_SRC: per-source end of frame.
- `s_axis_tready` out NUM_SRC: per-source ready.
- `s_eth_type` in 16*NUM_SRC: per-source EtherType, sampled at grant.
- `m_axis_tdata` out 8: byte stream to the MAC.
- `m_axis_tvalid` out 1: valid to the MAC.
- `m_axis_tlast` out 1: end of frame to the MAC.
- `m_axis_tuser` out 1: 1 marks the frame as aborted/errored; valid on the tlast beat.
- `m_axis_tready` in 1: ready from the MAC.
- `m_eth_type` out 16: EtherType of the current frame, stable from grant until the next grant.
- `grant_id` out 3: index of the granted source.
- `busy` out 1: 1 in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE: pick a source and go to XFER.
  - XFER: on accepted beat with tlast=1, go to IFG.
  - IFG: hold for `IFG_CYCLES`, then go to IDLE.
  - ABORT and DRAIN: exist only with the timeout feature (see Configuration).
- Grant rule in IDLE:
  - A source requests when its `s_axis_tvalid[i]`=1.
  - Search starts at `last_grant+1` modulo `NUM_SRC` and takes the first requester.
  - In the grant cycle: `grant_id` and `m_eth_type` register, `busy` goes to 1, state goes to XFER.
- XFER datapath is combinational pass-through of the granted source:
  - `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` follow the granted source.
  - `s_axis_tready[grant_id]` = `m_axis_tready`.
  - All other `s_axis_tready` bits are 0.
  - `m_axis_tuser` = 0.
- Beat acceptance: a beat counts only when `m_axis_tvalid` & `m_axis_tready`.
- `last_grant` updates when the tlast beat is accepted.
- IFG counter:
  - Loads `IFG_CYCLES-1` on entry and decrements.
  - Exits to IDLE at 0.
  - `IFG_CYCLES`=0 skips IFG and goes straight to IDLE.
- Outside XFER, ABORT and DRAIN: `m_axis_tvalid`=0 and all `s_axis_tready`=0.
- Simultaneous requests: all sources asserting tvalid in the same cycle are served in strict rotation order.
- A source dropping tvalid before it is granted loses nothing; no request is latched.
- Reset values:
  - State IDLE; `grant_id` 0; `last_grant` = `NUM_SRC-1`, so source 0 is first.
  - `m_eth_type` 0; `busy` 0; all `m_axis_*` and `s_axis_tready` 0.
- Reset mid-frame drops the frame silently. The MAC is expected to be reset by the same `sys_rst`.

## Timing
- Grant latency: 1 cycle from first tvalid seen in IDLE to the first beat being presentable in XFER.
- Data latency: 0 cycles through XFER, combinational.
- Back-to-back frames from one source:
  - Earliest next first beat is `IFG_CYCLES+1` cycles after the accepted tlast beat.
  - The +1 is the IDLE grant cycle.
- `m_eth_type` is valid from the first XFER cycle.

## Configuration
- Macro `ETH_TX_ARB_TIMEOUT_EN`.
- Defined, stall counter:
  - In XFER it counts cycles where the granted tvalid=0, and clears on any tvalid=1.
  - Reaching `TIMEOUT_CYCLES` → ABORT.
- Defined, ABORT:
  - Drive one beat: `m_axis_tvalid`=1, `m_axis_tdata`=0x00, `m_axis_tlast`=1, `m_axis_tuser`=1.
  - All `s_axis_tready`=0.
  - When `m_axis_tready` accepts it → DRAIN.
- Defined, DRAIN:
  - `s_axis_tready[grant_id]`=1 and `m_axis_tvalid`=0; source beats are discarded.
  - The discarded tlast beat → IFG.
- Not defined: no counter, and the ABORT/DRAIN states are absent. A stalled source holds the grant indefinitely and `m_axis_tuser` is tied 0.

## Structure
- Package `eth_pkg`: state encodings, `ETH_TYPE_IPV4`=0x0800, `ETH_TYPE_ARP`=0x0806, `GRANT_W`=3.
- One sub-module, `rr_arbiter`: combinational rotating-priority picker, taking req[NUM_SRC] and last_grant and returning grant index and a valid flag.
- The FSM, counters and mux stay in the top module.

## Test plan
- Single source 0 sends a 4-byte frame 0x11..0x14 with `s_eth_type`=0x0800 → `m_axis` carries the same 4 bytes, tlast on 0x14, `m_eth_type`=0x0800, `grant_id`=0.
- Sources 0 and 1 request in the same cycle with 3-byte frames:
  - Source 0 goes first, then source 1.
  - Between source 0's tlast and source 1's first beat exactly `IFG_CYCLES+1`=13 cycles pass.
- Source 1 continuously requesting plus source 0 requesting → grants alternate 0, 1, 0, 1; no source starved.
- `m_axis_tready` toggled 1-0-1-0 during a frame → every byte delivered once, in order; the source sees tready only when the MAC is ready.
- With `ETH_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16:
  - Source stops after 2 of 6 bytes → after 16 idle cycles one beat 0x00 with tlast=1, tuser=1.
  - The remaining 4 source bytes are then drained with `m_axis_tvalid`=0.
- `sys_rst` pulsed mid-frame → all outputs return to reset values asynchronously, and the next grant goes to source 0.
